dm_access_ctrl: RTL and testbench

- Initiator-side controller for the 128-word data memory.
- Accepts one load/store request at a time from the multi-cycle CPU datapath.
- Stores: drives the memory write enable, word address and write data. Byte/halfword stores use a read-modify-write sequence.
- Loads: returns byte, halfword or word data, sign- or zero-extended, with a one-cycle done pulse.

---
 rtl/dm_access_ctrl_pkg.sv | 28 ++
 rtl/dm_lane_fmt.sv | 48 ++++
 rtl/dm_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings and small helpers for the data-memory access controller.
package dm_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned LANE_W        = 2;
  localparam int unsigned HALF_LANE_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_DONE
  } state_t;

  // The reserved size code behaves as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
    return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != '0));
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter: sub-word store merge and load extract/extend.
module dm_lane_fmt
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned LITTLE_END = 1
) (
  input  logic [31:0]       i_word,
  input  logic [31:0]       i_data,
  input  logic [1:0]        i_size,
  input  logic [LANE_W-1:0] i_lane,
  input  logic              i_sext,
  output logic [31:0]       o_merged,
  output logic [31:0]       o_extract
);

  logic [4:0]  w_boff;
  logic [4:0]  w_hoff;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_boff    = (LITTLE_END != 0) ? {i_lane, 3'b000} : {~i_lane, 3'b000};
    w_hoff    = (LITTLE_END != 0) ? {i_lane[HALF_LANE_BIT], 4'b0000}
                                  : {~i_lane[HALF_LANE_BIT], 4'b0000};
    w_byte    = 8'(i_word >> w_boff);
    w_half    = 16'(i_word >> w_hoff);
    w_mask    = '1;
    w_ins     = i_data;
    o_extract = i_word;
    case (i_size)
      SZ_BYTE: begin
        w_mask    = 32'h0000_00FF << w_boff;
        w_ins     = 32'(i_data[7:0]) << w_boff;
        o_extract = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        w_mask    = 32'h0000_FFFF << w_hoff;
        w_ins     = 32'(i_data[15:0]) << w_hoff;
        o_extract = {{16{i_sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
    o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Single-outstanding load/store controller for the word-organised data memory.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned AW         = 7,
  parameter int unsigned LITTLE_END = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          DMWr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_dmwr;
  logic [31:0]       r_rdata;
  logic [AW-1:0]     r_mem_addr;
  logic [31:0]       r_mem_din;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_wdata;

  logic [1:0]        w_size;
  logic              w_mis;
  logic [31:0]       w_merged;
  logic [31:0]       w_extract;
  logic              w_unused_addr;

  assign w_size        = norm_size(size);
  assign w_mis         = is_misaligned(w_size, addr[LANE_W-1:0]);
  assign w_unused_addr = ^addr[31:AW+2];

  // Both LOAD and RMW_RD consume the word currently presented on mem_dout.
  dm_lane_fmt #(
    .LITTLE_END(LITTLE_END)
  ) u_lane_fmt (
    .i_word   (mem_dout),
    .i_data   (r_wdata),
    .i_size   (r_size),
    .i_lane   (r_lane),
    .i_sext   (r_sext),
    .o_merged (w_merged),
    .o_extract(w_extract)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dmwr     <= 1'b0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_size     <= SZ_BYTE;
      r_sext     <= 1'b0;
      r_lane     <= '0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_busy     <= 1'b1;
            r_err      <= w_mis;
            r_size     <= w_size;
            r_sext     <= sext;
            r_lane     <= addr[LANE_W-1:0];
            r_wdata    <= wdata;
            r_mem_addr <= addr[AW+1:2];
            if (w_mis) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (!we) begin
              r_state <= ST_LOAD;
            end else if (w_size == SZ_WORD) begin
              r_state   <= ST_WRITE;
              r_dmwr    <= 1'b1;
              r_mem_din <= wdata;
            end else begin
              r_state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          r_rdata <= w_extract;
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        // mem_din doubles as the merge register for the following write.
        ST_RMW_RD: begin
          r_mem_din <= w_merged;
          r_dmwr    <= 1'b1;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          r_dmwr  <= 1'b0;
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign DMWr     = r_dmwr;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomised bench for dm_access_ctrl against a byte-addressed memory model.
module tb_dm_access_ctrl;

  localparam int unsigned AW = 7;

  logic          clk;
  logic          rstn;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sext;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   rdata;
  logic          DMWr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0] mem [128];
  logic [7:0]  rb  [512];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_din;
  int          last_lat;

  dm_access_ctrl #(.AW(AW), .LITTLE_END(1)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .DMWr(DMWr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (DMWr) mem[mem_addr] <= mem_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [6:0] w);
    return {rb[{w, 2'd3}], rb[{w, 2'd2}], rb[{w, 2'd1}], rb[{w, 2'd0}]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [8:0] ba, input logic [1:0] szn, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    if (szn == 2'd0) begin
      b = rb[ba];
      return (sx && b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
    end else if (szn == 2'd1) begin
      h = {rb[ba + 9'd1], rb[ba]};
      return (sx && h >= 16'd32768) ? 32'(h) - 32'h10000 : 32'(h);
    end
    return ref_word(ba[8:2]);
  endfunction

  task automatic ref_store(input logic [8:0] ba, input logic [1:0] szn, input logic [31:0] wd);
    int nbytes;
    nbytes = (szn == 2'd0) ? 1 : (szn == 2'd1) ? 2 : 4;
    for (int k = 0; k < nbytes; k++) rb[ba + 9'(k)] = wd[8*k +: 8];
  endtask

  // One complete transaction: predict, drive, watch to completion, compare.
  task automatic run(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic pulse);
    logic [1:0] szn;
    logic       mis;
    logic [6:0] widx;
    logic [8:0] ba;
    logic [31:0] exp_word;
    int         exp_lat, exp_wr, cyc, nwr, extra;
    logic       seen;
    szn  = (sz == 2'd3) ? 2'd2 : sz;
    mis  = (szn == 2'd1 && a[0]) || (szn == 2'd2 && a[1:0] != 2'd0);
    ba   = a[8:0];
    widx = a[8:2];
    exp_wr = (w && !mis) ? 1 : 0;
    if (mis) exp_lat = 1;
    else if (w && szn != 2'd2) exp_lat = 3;
    else exp_lat = 2;
    if (!w && !mis) exp_rdata = ref_load(ba, szn, sx);
    if (w && !mis) ref_store(ba, szn, wd);
    exp_word = ref_word(widx);

    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    cyc = 0; nwr = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (DMWr) begin
        nwr++;
        last_din = mem_din;
        check("wr_addr", 32'(mem_addr), 32'(widx));
        check("wr_din", mem_din, exp_word);
      end
      if (done) seen = 1'b1;
      req = (pulse && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    req = 1'b0;
    last_lat = cyc;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("err", 32'(err), 32'(mis));
    check("rdata", rdata, exp_rdata);
    check("write_count", 32'(nwr), 32'(exp_wr));
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || DMWr) extra++;
    end
    check("idle_after_done", 32'(extra), 32'd0);
    check("mem_word", mem[widx], ref_word(widx));
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int ndone, first, second;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      mem[i] = v;
      for (int k = 0; k < 4; k++) rb[4*i + k] = v[8*k +: 8];
    end
    rstn = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dmwr", 32'(DMWr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    rstn = 1'b1;

    // Directed cases from the intended use.
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    check("tp_wst_din", last_din, 32'hDEADBEEF);
    check("tp_wst_lat", 32'(last_lat), 32'd2);
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
    run(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, 1'b0);
    check("tp_bst_din", last_din, 32'h11AB3344);
    check("tp_bst_lat", 32'(last_lat), 32'd3);
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 1'b0);
    run(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0);
    check("tp_lb", rdata, 32'hFFFFFFFF);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    check("tp_lbu", rdata, 32'h00000080);
    run(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b0);
    check("tp_lh0", rdata, 32'h00007F01);
    run(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    check("tp_lh2", rdata, 32'hFFFF80FF);
    run(1'b1, 2'd2, 1'b0, 32'h0E, 32'h12345678, 1'b0);
    check("tp_mis_err", 32'(err), 32'd1);
    check("tp_mis_lat", 32'(last_lat), 32'd1);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    check("tp_lw_err_clr", 32'(err), 32'd0);
    check("tp_lw", rdata, 32'h80FF7F01);
    run(1'b1, 2'd2, 1'b0, 32'h210, 32'hCAFEF00D, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0);
    check("tp_wrap", rdata, 32'hCAFEF00D);
    run(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000005C, 1'b1);

    // req held high: re-accept only in the IDLE cycle after each done.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h20; wdata = 32'h5A5A0001;
    ref_store(9'h20, 2'd2, 32'h5A5A0001);
    ndone = 0; first = 0; second = 0;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) first = s;
        else if (second == 0) second = s;
      end
    end
    req = 1'b0;
    check("b2b_dones", 32'(ndone), 32'd3);
    check("b2b_gap", 32'(second - first), 32'd3);
    repeat (2) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_mem", mem[8], ref_word(7'd8));

    // Reset during RMW_RD of a byte store: no write reaches memory.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h12; wdata = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rmw_rst_busy", 32'(busy), 32'd0);
    check("rmw_rst_dmwr", 32'(DMWr), 32'd0);
    check("rmw_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rmw_rst_mem_din", mem_din, 32'd0);
    check("rmw_rst_rdata", rdata, 32'd0);
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rmw_rst_dmwr_hold", 32'(DMWr), 32'd0);
    rstn = 1'b1;
    check("rmw_rst_mem", mem[4], ref_word(7'd4));
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    run(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b0);

    // Random traffic over a small window of words to force overlap.
    for (int t = 0; t < 300; t++) begin
      a = ($urandom & ~32'h1FC) | (32'($urandom_range(0, 7)) << 2);
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
